serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder for the datapath.
- Latches two operands and a carry-in, then feeds one bit pair per clock, LSB first, into a single full_adder instance.
- Registers the carry between cycles and shifts sum bits into a result register.
- Start/ready/done handshake; sits between the operand source (register file / ALU operand mux) and the result writeback register.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default datapath width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock, LSB first, through one full_adder.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_shift;
  logic             carry, c_msb;
  logic             fa_s, fa_cout;
  logic [CW-1:0]    cnt, cnt_inc;
  logic             inc_c;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  generate
    if (WIDTH == 1) begin : g_narrow
      assign sum_shift = fa_s;
    end else begin : g_wide
      assign sum_shift = {fa_s, sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // Ripple incrementer keeps the counter free of behavioural adders.
  always_comb begin
    cnt_inc = '0;
    inc_c   = 1'b1;
    for (int unsigned i = 0; i < CW; i++) begin
      cnt_inc[i] = cnt[i] ^ inc_c;
      inc_c      = inc_c & cnt[i];
    end
  end

  assign last_bit = (cnt == LAST);
  assign overflow = c_msb ^ cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results are loaded on the last RUN edge so they are already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            sum_sh <= '0;
          end
        end
        RUN: begin
          sum_sh <= sum_shift;
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt_inc;
          if (last_bit) begin
            c_msb <= carry;
            sum   <= sum_shift;
            cout  <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, 1 and 32.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a_drv = '0, b_drv = '0;
  logic        cin_drv = 1'b0;
  logic        start8 = 1'b0, start1 = 1'b0, start32 = 1'b0;

  logic        ready8, busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        ready1, busy1, done1, cout1, ovf1;
  logic [0:0]  sum1;
  logic        ready32, busy32, done32, cout32, ovf32;
  logic [31:0] sum32;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8));

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a_drv[0:0]), .b(b_drv[0:0]), .cin(cin_drv),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .overflow(ovf1));

  serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a_drv), .b(b_drv), .cin(cin_drv),
    .ready(ready32), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32));

  // {ready, busy, done} of the selected instance
  function automatic logic [2:0] flags(input int w);
    case (w)
      1:       return {ready1, busy1, done1};
      8:       return {ready8, busy8, done8};
      default: return {ready32, busy32, done32};
    endcase
  endfunction

  // {overflow, cout, sum zero-extended}
  function automatic logic [33:0] result(input int w);
    case (w)
      1:       return {ovf1, cout1, 31'd0, sum1};
      8:       return {ovf8, cout8, 24'd0, sum8};
      default: return {ovf32, cout32, sum32};
    endcase
  endfunction

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       start1 = v;
      8:       start8 = v;
      default: start32 = v;
    endcase
  endtask

  // Issues one add from IDLE at a negedge; lat counts negedges from the accepting edge to done.
  task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci,
                       output logic [33:0] res, output int lat, output int nbusy, output logic tail_ok);
    logic [2:0] f;
    logic found;
    a_drv = a; b_drv = b; cin_drv = ci;
    set_start(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(w, 1'b0);
    a_drv = ~a; b_drv = ~b; cin_drv = ~ci;
    lat = 1; nbusy = 0; found = 1'b0; res = '0;
    for (int i = 0; i < 80; i++) begin
      f = flags(w);
      if (f[1]) nbusy++;
      if (f[0]) begin
        found = 1'b1;
        res = result(w);
        break;
      end
      lat++;
      @(negedge clk);
    end
    if (!found) lat = -1;
    @(negedge clk);
    f = flags(w);
    tail_ok = (f == 3'b100);
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({ready8, busy8, done8, sum8, cout8, ovf8} !== {3'b100, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL reset_values got=%b exp=%b", {ready8, busy8, done8, sum8, cout8, ovf8}, {3'b100, 8'h00, 2'b00});
    end
    total++;
    if ({ready32, busy32, done32, sum32, ovf32} !== {3'b100, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values32 got=%b_%h exp=100_00000000", {ready32, busy32, done32}, sum32);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check8(input string name, input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic [7:0] es, input logic eco, input logic eov);
    logic [33:0] r;
    int lat, nb;
    logic tk;
    do_op(8, a, b, ci, r, lat, nb, tk);
    total++;
    if ({r[33], r[32], r[7:0]} !== {eov, eco, es}) begin
      bad++;
      $display("FAIL %s result got ov=%b co=%b s=%h exp ov=%b co=%b s=%h", name, r[33], r[32], r[7:0], eov, eco, es);
    end
    total++;
    if (lat !== 9 || nb !== 8) begin
      bad++;
      $display("FAIL %s timing got lat=%0d busy=%0d exp lat=9 busy=8", name, lat, nb);
    end
    total++;
    if (tk !== 1'b1) begin
      bad++;
      $display("FAIL %s after_done got=%b exp=1 (ready, done low)", name, tk);
    end
  endtask

  task automatic test_basic;
    check8("basic", 32'h3C, 32'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
  endtask

  task automatic test_carry;
    check8("carry_chain", 32'hFF, 32'h00, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    check8("ovf_pos", 32'h7F, 32'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    check8("ovf_neg", 32'h80, 32'h80, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_reset_abort;
    int ndone;
    a_drv = 32'hFF; b_drv = 32'h01; cin_drv = 1'b0;
    start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({ready8, busy8, done8, sum8, cout8, ovf8} !== {3'b100, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL abort_values got=%b exp=%b", {ready8, busy8, done8, sum8, cout8, ovf8}, {3'b100, 8'h00, 2'b00});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d pulses exp=0", ndone);
    end
    check8("after_abort", 32'hA5, 32'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_handshake;
    logic [7:0] opa[2] = '{8'h3C, 8'h11};
    logic [7:0] opb[2] = '{8'h0F, 8'h22};
    logic       opc[2] = '{1'b0, 1'b1};
    logic [7:0] exps[2] = '{8'h4B, 8'h34};
    int issued = 0;
    int ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin
        total++;
        if (ndone >= 2 || sum8 !== exps[ndone]) begin
          bad++;
          $display("FAIL handshake_op%0d got=%h exp=%h", ndone, sum8, (ndone < 2) ? exps[ndone] : 8'hxx);
        end
        ndone++;
      end
      if (ready8) begin
        if (issued < 2) begin
          start8 = 1'b1; a_drv = {24'd0, opa[issued]}; b_drv = {24'd0, opb[issued]}; cin_drv = opc[issued];
          issued++;
        end else begin
          start8 = 1'b0;
        end
      end else begin
        start8 = 1'b1; a_drv = $urandom; b_drv = $urandom; cin_drv = 1'($urandom);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    total++;
    if (ndone !== 2) begin
      bad++;
      $display("FAIL handshake_done_count got=%0d exp=2", ndone);
    end
  endtask

  task automatic test_random(input int w);
    logic [31:0] m, ra, rb, es;
    logic        rc, eco, eov;
    logic [63:0] e;
    logic [33:0] r;
    int lat, nb;
    logic tk;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom & m; rb = $urandom & m; rc = 1'($urandom);
      if (i == 0) begin ra = m; rb = m; rc = 1'b1; end
      if (i == 1) begin ra = 0; rb = 0; rc = 1'b0; end
      e   = 64'(ra) + 64'(rb) + 64'(rc);
      es  = e[31:0] & m;
      eco = e[w];
      eov = (ra[w-1] == rb[w-1]) && (es[w-1] != ra[w-1]);
      do_op(w, ra, rb, rc, r, lat, nb, tk);
      total++;
      if (r !== {eov, eco, es}) begin
        bad++;
        $display("FAIL rand_w%0d a=%h b=%h c=%b got=%h exp=%h", w, ra, rb, rc, r, {eov, eco, es});
      end
      total++;
      if (lat !== w + 1 || nb !== w || tk !== 1'b1) begin
        bad++;
        $display("FAIL rand_w%0d_timing got lat=%0d busy=%0d tail=%b exp lat=%0d busy=%0d tail=1", w, lat, nb, tk, w + 1, w);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_carry;
    test_overflow;
    test_reset_abort;
    test_handshake;
    @(negedge clk);
    test_random(1);
    test_random(32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
